alu_seq_exec: RTL and testbench
===============================

# alu_seq_exec

Multi-cycle ALU execution unit for the RISC-V datapath. It consumes the 4-bit ALU operation code produced by the ALU control decoder, plus two operands, and returns a registered result and zero flag. Logic ops complete in one cycle. Shifts are executed bit-serially and multiply by shift-add. A start/ready/done handshake lets the core stall on long operations.

## Interface
- DATA_WIDTH, 32, operand/result width; must be a power of two, ≥ 8
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- start_i  input  1  request; accepted on a rising edge where start_i=1 and ready_o=1
- ALU_Operation_i  input  4  operation code, sampled on accept
- A_i  input  DATA_WIDTH  operand A, sampled on accept
- B_i  input  DATA_WIDTH  operand B, sampled on accept; shift amount = B_i[log2(DATA_WIDTH)-1:0]
- ready_o  output  1  unit can accept a request this cycle
- done_o  output  1  one-cycle pulse; result_o/zero_o valid from this cycle
- result_o  output  DATA_WIDTH  registered result, held until next completion
- zero_o  output  1  registered (result_o == 0)

## Operation
- Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT (signed), 1001 SLTU, 1010 MUL (low DATA_WIDTH bits of the product). 1011–1111 are undefined: result 0, single-cycle.
- ADD/SUB wrap modulo 2^DATA_WIDTH; no overflow output. SLT/SLTU return 1 or 0, zero-extended.
- States:
  - IDLE: ready_o=1.
  - SHIFT: ready_o=0.
  - MUL: ready_o=0.
- IDLE, accept, opcode single-cycle: result registered at the accept edge; stay in IDLE.
- IDLE, accept, shift:
  - Load A into the work register and the shift amount into a down-counter.
  - If the amount is 0: complete at the accept edge with result = A, stay in IDLE.
  - Otherwise go to SHIFT.
- SHIFT: each edge shifts the work register 1 bit and decrements the counter.
  - SLL fills with 0. SRL fills with 0. SRA replicates the sign bit.
  - The edge that brings the counter to 0 completes and returns to IDLE.
- IDLE, accept, MUL:
  - Load multiplicand = A, multiplier = B, accumulator = 0, counter = DATA_WIDTH. Go to MUL.
- MUL: each edge does the following, then decrements the counter.
  - If multiplier[0]=1, acc += multiplicand.
  - multiplicand <<= 1; multiplier >>= 1.
  - The edge that brings the counter to 0 completes and returns to IDLE.
- Completion edge actions:
  - Load result_o.
  - Load zero_o.
  - Set done_o=1 for exactly the following cycle.
- start_i while ready_o=0 is ignored (not queued). Operand and opcode inputs are don't-care except on accept.

## Timing
- Reset (asynchronous assertion, any state): state=IDLE, ready_o=1, done_o=0, result_o=0, zero_o=1, counters and work registers 0.
- Reset during SHIFT/MUL aborts the operation; done_o is never raised for it.
- Let E0 be the accept edge. done_o is high in the cycle after edge E_L, where L is:
  - L=0 for single-cycle opcodes and for shifts by 0.
  - L=shift amount for SLL/SRL/SRA.
  - L=DATA_WIDTH for MUL.
- ready_o is high in the completion cycle, so a start_i in the done_o cycle is accepted: zero-bubble back-to-back issue.
- Single-cycle ops sustain one accept per cycle. done_o stays high over consecutive completions.
- result_o and zero_o change only on completion edges and on reset.

## Test plan
- Reset, then check idle outputs: assert reset=0 mid-cycle with no clock edge. Outputs go immediately to ready_o=1, done_o=0, result_o=0, zero_o=1.
- Single-cycle back-to-back: issue ADD, SUB and SLT on three consecutive cycles with start_i held high. Operands: ADD 0xFFFFFFFF,1; SUB 0,1; SLT 0x80000000,1. Results appear on the following three cycles: 0x00000000 (zero_o=1), 0xFFFFFFFF, 1. done_o stays high for 3 cycles.
- Shifts:
  - SRA A=0x80000000, B=31: done_o exactly 31 cycles after accept, result 0xFFFFFFFF.
  - SRL same operands: result 0x00000001.
  - SLL A=5, B=0: done_o next cycle, result 5.
- MUL A=0xFFFFFFFF, B=3: ready_o low for 32 cycles, then done_o with result 0xFFFFFFFD. A start_i pulsed mid-operation is ignored and produces no extra done_o.
- Reset mid-MUL at cycle 10: no done_o; result_o=0 and ready_o=1. A following ADD 2,3 returns 5 one cycle after accept.
- Undefined opcode 1111 with any operands: done_o next cycle, result 0, zero_o=1.

Source files
------------

// File: rtl/alu_seq_exec.sv
// alu_seq_exec: multi-cycle ALU with single-cycle logic ops, bit-serial shifts and shift-add multiply
module alu_seq_exec #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            ALU_Operation_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o
);
  localparam int SW = $clog2(DATA_WIDTH);
  localparam logic [SW:0] CNT_MUL = (SW+1)'(DATA_WIDTH);
  localparam logic [SW:0] CNT_ONE = (SW+1)'(1);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                         OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                         OP_SLT = 4'd8, OP_SLTU = 4'd9, OP_MUL = 4'd10;
  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] work, work_n, mcand, mplier, acc, acc_n, alu_res, fin_val;
  logic [SW:0] cnt;
  logic [SW-1:0] amt;
  logic [3:0] op_q;
  logic accept, is_shift, is_mul, fin;
  // request decode and one-cycle ALU result
  always_comb begin
    accept = start_i && state == IDLE;
    amt = B_i[SW-1:0];
    is_shift = ALU_Operation_i == OP_SLL || ALU_Operation_i == OP_SRL || ALU_Operation_i == OP_SRA;
    is_mul = ALU_Operation_i == OP_MUL;
    alu_res = ALU_Operation_i == OP_ADD  ? A_i + B_i :
              ALU_Operation_i == OP_SUB  ? A_i - B_i :
              ALU_Operation_i == OP_AND  ? A_i & B_i :
              ALU_Operation_i == OP_OR   ? A_i | B_i :
              ALU_Operation_i == OP_XOR  ? A_i ^ B_i :
              ALU_Operation_i == OP_SLT  ? {{(DATA_WIDTH-1){1'b0}}, $signed(A_i) < $signed(B_i)} :
              ALU_Operation_i == OP_SLTU ? {{(DATA_WIDTH-1){1'b0}}, A_i < B_i} : '0;
  end
  // next values of the iterative datapath and completion detection
  always_comb begin
    work_n = op_q == OP_SLL ? work << 1 :
             op_q == OP_SRA ? {work[DATA_WIDTH-1], work[DATA_WIDTH-1:1]} : work >> 1;
    acc_n = acc + (mplier[0] ? mcand : '0);
    fin = state == IDLE ? accept && !is_mul && !(is_shift && amt != '0) : cnt == CNT_ONE;
    fin_val = state == IDLE ? (is_shift ? A_i : alu_res) : state == SHIFT ? work_n : acc_n;
  end
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  // next-state logic
  always_comb begin
    state_n = state == IDLE ? (accept && is_mul ? MUL : accept && is_shift && amt != '0 ? SHIFT : IDLE) :
              cnt == CNT_ONE ? IDLE : state;
  end
  // output decode
  always_comb begin
    ready_o = state == IDLE;
  end
  // operand capture, iteration and result registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      op_q <= '0;
      work <= '0;
      cnt <= '0;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      done_o <= 1'b0;
      result_o <= '0;
      zero_o <= 1'b1;
    end else begin
      if (accept) begin
        op_q <= ALU_Operation_i;
        work <= A_i;
        cnt <= is_mul ? CNT_MUL : {1'b0, amt};
        mcand <= A_i;
        mplier <= B_i;
        acc <= '0;
      end else if (state == SHIFT) begin
        work <= work_n;
        cnt <= cnt - 1'b1;
      end else if (state == MUL) begin
        acc <= acc_n;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt - 1'b1;
      end
      done_o <= fin;
      if (fin) begin
        result_o <= fin_val;
        zero_o <= fin_val == '0;
      end
    end
endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: directed checks of alu_seq_exec latency, results and handshake
module tb_alu_seq_exec;
  logic clk = 0, reset = 1, start_i = 0;
  logic [3:0] op = 0;
  logic [31:0] a = 0, b = 0;
  logic ready_o, done_o, zero_o;
  logic [31:0] result_o;
  int n_cmp = 0, n_bad = 0;
  typedef struct {logic [3:0] o; logic [31:0] x, y, r; int l;} vec_t;
  vec_t tv [8];
  alu_seq_exec #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .ALU_Operation_i(op),
    .A_i(a), .B_i(b), .ready_o(ready_o), .done_o(done_o),
    .result_o(result_o), .zero_o(zero_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
    start_i = 1; op = o; a = x; b = y; lat = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      start_i = 0;
      if (done_o) begin
        lat = k;
        break;
      end
    end
  endtask
  initial begin
    int lat, low, dn, dk;
    tv[0] = '{4'd2, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 0};
    tv[1] = '{4'd3, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 0};
    tv[2] = '{4'd4, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 0};
    tv[3] = '{4'd9, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0};
    tv[4] = '{4'd8, 32'h00000001, 32'h80000000, 32'h00000000, 0};
    tv[5] = '{4'd1, 32'h00000005, 32'h00000003, 32'h00000002, 0};
    tv[6] = '{4'd7, 32'h40000000, 32'h00000024, 32'h04000000, 4};
    tv[7] = '{4'd10, 32'h00000007, 32'h00000006, 32'h0000002A, 32};
    #3 reset = 0;
    #1;
    chk("rst_ready", ready_o, 1);
    chk("rst_done", done_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_zero", zero_o, 1);
    @(negedge clk) reset = 1;
    @(negedge clk);
    start_i = 1; op = 0; a = 32'hFFFFFFFF; b = 1;
    @(negedge clk);
    chk("b2b_add_done", done_o, 1);
    chk("b2b_add_res", result_o, 0);
    chk("b2b_add_zero", zero_o, 1);
    op = 1; a = 0; b = 1;
    @(negedge clk);
    chk("b2b_sub_done", done_o, 1);
    chk("b2b_sub_res", result_o, 32'hFFFFFFFF);
    chk("b2b_sub_zero", zero_o, 0);
    op = 8; a = 32'h80000000; b = 1;
    @(negedge clk);
    chk("b2b_slt_done", done_o, 1);
    chk("b2b_slt_res", result_o, 1);
    start_i = 0;
    @(negedge clk);
    chk("b2b_idle_done", done_o, 0);
    run(4'd7, 32'h80000000, 31, lat);
    chk("sra_lat", 32'(lat), 31);
    chk("sra_res", result_o, 32'hFFFFFFFF);
    @(negedge clk);
    chk("sra_pulse", done_o, 0);
    run(4'd6, 32'h80000000, 31, lat);
    chk("srl_lat", 32'(lat), 31);
    chk("srl_res", result_o, 1);
    run(4'd5, 5, 0, lat);
    chk("sll0_lat", 32'(lat), 0);
    chk("sll0_res", result_o, 5);
    foreach (tv[i]) begin
      run(tv[i].o, tv[i].x, tv[i].y, lat);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tv[i].l));
      chk($sformatf("vec%0d_res", i), result_o, tv[i].r);
    end
    start_i = 1; op = 10; a = 32'hFFFFFFFF; b = 3; low = 0; dn = 0; dk = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      start_i = k == 10;
      if (k == 10) begin op = 0; a = 1; b = 1; end
      if (!ready_o) low++;
      if (done_o) begin dn++; if (dk < 0) dk = k; end
    end
    start_i = 0;
    chk("mul_ready_low", 32'(low), 32);
    chk("mul_done_cnt", 32'(dn), 1);
    chk("mul_done_at", 32'(dk), 32);
    chk("mul_res", result_o, 32'hFFFFFFFD);
    start_i = 1; op = 10; a = 7; b = 9;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      start_i = 0;
    end
    #1 reset = 0;
    #1;
    chk("abort_ready", ready_o, 1);
    chk("abort_done", done_o, 0);
    chk("abort_result", result_o, 0);
    chk("abort_zero", zero_o, 1);
    #1 reset = 1;
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_o) dn++;
    end
    chk("abort_no_done", 32'(dn), 0);
    run(4'd0, 2, 3, lat);
    chk("post_add_lat", 32'(lat), 0);
    chk("post_add_res", result_o, 5);
    run(4'd15, 32'h12345678, 32'h9ABCDEF0, lat);
    chk("undef_lat", 32'(lat), 0);
    chk("undef_res", result_o, 0);
    chk("undef_zero", zero_o, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
